// File: rtl/rr_mux_arbiter_if.sv
// ----------------------------------------------------------------------------
// rr_mux_arbiter_if
// Bundles the requester-side inputs and the shared-bus outputs of the
// round-robin mux arbiter.
//   master : requesters/consumer side (drives req, data_in, out_ready)
//   slave  : arbiter side (drives gnt, sel, out_data, out_valid, beat_cnt)
// Signals:
//   req       [N_REQ]         per-requester request, held while data pending
//   data_in   [N_REQ*DATA_W]  packed payloads, requester i at [i*DATA_W +: DATA_W]
//   gnt       [N_REQ]         registered one-hot grant, zero when idle
//   sel       [SEL_W]         registered owner index / mux select
//   out_data  [DATA_W]        payload of the selected requester
//   out_valid                 owner present and still requesting
//   out_ready                 consumer accepts a beat
//   beat_cnt  [CNT_W]         beats moved in the current grant
// ----------------------------------------------------------------------------
interface rr_mux_arbiter_if #(
   parameter int N_REQ    = 4,
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 16
);
   localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = $clog2(MAX_HOLD + 1);

   logic [N_REQ-1:0]        req;
   logic [N_REQ*DATA_W-1:0] data_in;
   logic [N_REQ-1:0]        gnt;
   logic [SEL_W-1:0]        sel;
   logic [DATA_W-1:0]       out_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [CNT_W-1:0]        beat_cnt;

   modport master (
      output req, data_in, out_ready,
      input  gnt, sel, out_data, out_valid, beat_cnt
   );

   modport slave (
      input  req, data_in, out_ready,
      output gnt, sel, out_data, out_valid, beat_cnt
   );
endinterface

// File: rtl/rr_mux_arbiter.sv
// ----------------------------------------------------------------------------
// rr_mux_arbiter
// Round-robin arbiter and select sequencer for a shared N:1 datapath mux that
// feeds the frame-buffer write port. Produces one-hot grants, the mux select
// and a valid/ready beat handshake, and forces rotation after MAX_HOLD beats
// so no requester can starve the others.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    rr_mux_arbiter_if.slave (req, data_in, out_ready in;
//          gnt, sel, out_data, out_valid, beat_cnt out)
// Build option:
//   PRIORITY_OVERRIDE_EN  when defined, requester 0 wins every arbitration in
//                         which it requests (ptr is then left unchanged); an
//                         owner is never pre-empted mid-grant.
// ----------------------------------------------------------------------------
module rr_mux_arbiter #(
   parameter int N_REQ    = 4,
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   rr_mux_arbiter_if.slave bus
);
   localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = $clog2(MAX_HOLD + 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   typedef struct packed {
      logic             found;
      logic             ovr;
      logic [SEL_W-1:0] idx;
   } arb_t;

   state_t              state_r, state_s;
   logic [N_REQ-1:0]    gnt_r, gnt_s;
   logic [SEL_W-1:0]    sel_r, sel_s;
   logic [SEL_W-1:0]    ptr_r, ptr_s;
   logic [CNT_W-1:0]    cnt_r, cnt_s;
   logic                out_valid_s;
   logic                xfer_s;
   logic                hold_end_s;
   logic                release_s;
   logic                others_s;
   logic                excl_s;
   arb_t                arb_s;
   logic [DATA_W-1:0]   slot_s [N_REQ];

   // Index that follows i in circular order.
   function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] i);
      logic [SEL_W-1:0] n;
      if (int'(i) == N_REQ - 1) begin
         n = '0;
      end else begin
         n = i + SEL_W'(1);
      end
      return n;
   endfunction

   // First requester found scanning circularly from p; optionally masks out
   // one index (forced rotation away from the current owner).
   function automatic arb_t arbitrate(input logic [N_REQ-1:0] r,
                                      input logic [SEL_W-1:0] p,
                                      input logic             excl_en,
                                      input logic [SEL_W-1:0] excl_idx);
      arb_t             res;
      logic [N_REQ-1:0] m;
      logic [SEL_W-1:0] cand;
      res = '0;
      m   = r;
      if (excl_en) begin
         m[excl_idx] = 1'b0;
      end else begin
         m = r;
      end
      for (int k = 0; k < N_REQ; k++) begin
         cand = SEL_W'((int'(p) + k) % N_REQ);
         if (!res.found && m[cand]) begin
            res.found = 1'b1;
            res.idx   = cand;
         end else begin
            res = res;
         end
      end
`ifdef PRIORITY_OVERRIDE_EN
      if (m[0]) begin
         res.found = 1'b1;
         res.ovr   = 1'b1;
         res.idx   = '0;
      end else begin
         res.ovr   = 1'b0;
      end
`endif
      return res;
   endfunction

   // Unpack the payload bus so the owner's slice can be picked by index.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         slot_s[i] = bus.data_in[i*DATA_W +: DATA_W];
      end
   end

   assign out_valid_s = (state_r == GRANT) && bus.req[sel_r];
   assign xfer_s      = out_valid_s && bus.out_ready;
   assign hold_end_s  = xfer_s && (cnt_r == CNT_W'(MAX_HOLD - 1));
   assign release_s   = !bus.req[sel_r] || hold_end_s;
   // Anyone other than the owner waiting? gnt_r is the owner's one-hot in GRANT.
   assign others_s    = |(bus.req & ~gnt_r);
   // The owner is skipped only on a forced rotation with competition; a sole
   // requester simply gets re-granted.
   assign excl_s      = hold_end_s && others_s;
   assign arb_s       = arbitrate(bus.req, ptr_r, excl_s, sel_r);

   // Next-state, grant, select, pointer and beat counter.
   always_comb begin
      state_s = state_r;
      gnt_s   = gnt_r;
      sel_s   = sel_r;
      ptr_s   = ptr_r;
      cnt_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (arb_s.found) begin
               state_s = GRANT;
               gnt_s   = N_REQ'(1'b1) << arb_s.idx;
               sel_s   = arb_s.idx;
               ptr_s   = arb_s.ovr ? ptr_r : next_idx(arb_s.idx);
               cnt_s   = '0;
            end else begin
               cnt_s   = '0;
            end
         end
         GRANT: begin
            if (release_s) begin
               if (arb_s.found) begin
                  gnt_s = N_REQ'(1'b1) << arb_s.idx;
                  sel_s = arb_s.idx;
                  ptr_s = arb_s.ovr ? ptr_r : next_idx(arb_s.idx);
                  cnt_s = '0;
               end else begin
                  // sel keeps the last owner while idle.
                  state_s = IDLE;
                  gnt_s   = '0;
                  cnt_s   = '0;
               end
            end else if (xfer_s) begin
               cnt_s = cnt_r + CNT_W'(1);
            end else begin
               cnt_s = cnt_r;
            end
         end
         default: begin
            state_s = IDLE;
            gnt_s   = '0;
            cnt_s   = '0;
         end
      endcase
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         gnt_r   <= '0;
         sel_r   <= '0;
         ptr_r   <= '0;
         cnt_r   <= '0;
      end else begin
         state_r <= state_s;
         gnt_r   <= gnt_s;
         sel_r   <= sel_s;
         ptr_r   <= ptr_s;
         cnt_r   <= cnt_s;
      end
   end

   assign bus.gnt       = gnt_r;
   assign bus.sel       = sel_r;
   assign bus.beat_cnt  = cnt_r;
   assign bus.out_valid = out_valid_s;
   assign bus.out_data  = slot_s[sel_r];

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rr_mux_arbiter
// Directed steps followed by a randomized phase, each cycle compared against
// a behavioural model of the arbitration rules.
// ----------------------------------------------------------------------------
module tb_rr_mux_arbiter;
   localparam int N_REQ    = 4;
   localparam int DATA_W   = 8;
   localparam int MAX_HOLD = 8;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   // model state: busy flag, owner, last select, rr pointer, beat count
   int   m_busy;
   int   m_owner;
   int   m_sel;
   int   m_ptr;
   int   m_cnt;

   rr_mux_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) bus ();

   rr_mux_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy  = 0;
      m_owner = 0;
      m_sel   = 0;
      m_ptr   = 0;
      m_cnt   = 0;
   endtask

   // first requester at or after start (circular), skipping excl
   function automatic int pick(input int start, input int excl);
      int i;
      for (int k = 0; k < N_REQ; k++) begin
         i = (start + k) % N_REQ;
         if (bus.req[i] && i != excl) return i;
      end
      return -1;
   endfunction

   // advance the model across one rising edge using the current inputs
   task automatic model_edge();
      bit               xfer, dropped, full, ovr;
      int               excl, w;
      logic [N_REQ-1:0] own_mask;
      xfer = (m_busy != 0) && bus.req[m_sel] && bus.out_ready;
      excl = -1;
      ovr  = 1'b0;
      if (m_busy != 0) begin
         dropped = !bus.req[m_owner];
         full    = xfer && (m_cnt == MAX_HOLD - 1);
         if (!dropped && !full) begin
            if (xfer) m_cnt++;
            return;
         end
         own_mask = '0;
         own_mask[m_owner] = 1'b1;
         if (full && ((bus.req & ~own_mask) != '0)) excl = m_owner;
      end else if (bus.req == '0) begin
         return;
      end
      w = pick(m_ptr, excl);
`ifdef PRIORITY_OVERRIDE_EN
      if (bus.req[0] && excl != 0) begin
         w   = 0;
         ovr = 1'b1;
      end
`endif
      if (w >= 0) begin
         m_busy  = 1;
         m_owner = w;
         m_sel   = w;
         m_cnt   = 0;
         if (!ovr) m_ptr = (w + 1) % N_REQ;
      end else begin
         m_busy = 0;
         m_cnt  = 0;
      end
   endtask

   // one clock: check combinational outputs, clock, check registered outputs
   task automatic step();
      logic [N_REQ-1:0] eg;
      #1;
      check("out_valid", bus.out_valid, (m_busy != 0) && bus.req[m_sel]);
      check("out_data", bus.out_data, bus.data_in[m_sel*DATA_W +: DATA_W]);
      model_edge();
      @(posedge clk);
      #1;
      eg = '0;
      if (m_busy != 0) eg[m_owner] = 1'b1;
      check("gnt", bus.gnt, eg);
      check("sel", bus.sel, m_sel);
      check("beat_cnt", bus.beat_cnt, m_cnt);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.req       = '0;
      bus.data_in   = '0;
      bus.out_ready = 1'b0;
      model_reset();

      // reset values
      #3;
      check("rst_gnt", bus.gnt, 4'b0000);
      check("rst_sel", bus.sel, 2'd0);
      check("rst_beat", bus.beat_cnt, 4'd0);
      check("rst_valid", bus.out_valid, 1'b0);
      bus.data_in = 32'hDDCC_BBAA;
      #1;
      check("rst_out_data", bus.out_data, 8'hAA);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // idle with no requests
      repeat (10) step();

      // single request from requester 2
      bus.data_in[2*DATA_W +: DATA_W] = 8'hA5;
      bus.req       = 4'b0100;
      bus.out_ready = 1'b1;
      step();
      #1;
      check("single_gnt", bus.gnt, 4'b0100);
      check("single_sel", bus.sel, 2'd2);
      check("single_data", bus.out_data, 8'hA5);
      check("single_valid", bus.out_valid, 1'b1);
      repeat (4) step();
      check("single_beat4", bus.beat_cnt, 4'd4);

      // all request: rotation with forced release every MAX_HOLD beats
      bus.req = 4'b1111;
      repeat (4 * MAX_HOLD + 4) step();

      // owner 1 stalls
      bus.req = 4'b0010;
      repeat (2) step();
      check("stall_gnt0", bus.gnt, 4'b0010);
      bus.out_ready = 1'b0;
      repeat (20) step();
      check("stall_gnt", bus.gnt, 4'b0010);
      bus.out_ready = 1'b1;
      repeat (3) step();

      // owner 3 drops with nobody else waiting
      bus.req = 4'b1000;
      repeat (2) step();
      bus.req = 4'b0000;
      step();
      check("idle_gnt", bus.gnt, 4'b0000);
      check("idle_sel", bus.sel, 2'd3);

      // reset asserted mid-grant at beat 5
      bus.req = 4'b0001;
      repeat (6) step();
      check("pre_rst_beat", bus.beat_cnt, 4'd5);
      rst_n = 1'b0;
      #1;
      check("mid_rst_gnt", bus.gnt, 4'b0000);
      check("mid_rst_beat", bus.beat_cnt, 4'd0);
      check("mid_rst_valid", bus.out_valid, 1'b0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 3) == 0) bus.req = N_REQ'($urandom_range(0, 15));
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.data_in   = $urandom;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
Round-robin arbiter and select sequencer for a shared N:1 datapath mux in the game engine. It decides which of N_REQ requesters (sprite, score and background writers) drives the single shared output bus toward the frame-buffer write port. It generates the one-hot grants, the mux select, and the valid/ready beat handshake. It also enforces a maximum hold length so no requester can starve the others.

Parameters:
N_REQ, 4, number of requesters (2..8; non-power-of-2 allowed)
DATA_W, 8, payload width per requester
MAX_HOLD, 16, maximum beats per grant before forced rotation (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  N_REQ  per-requester request; held high while the requester has data
data_in  input  N_REQ*DATA_W  packed payloads; requester i occupies bits [i*DATA_W +: DATA_W]
gnt  output  N_REQ  registered one-hot grant; all zero when idle
sel  output  $clog2(N_REQ)  registered index of current owner; drives the shared mux select
out_data  output  DATA_W  data_in slice selected by sel (combinational)
out_valid  output  1  asserted when state==GRANT and req[sel]==1
out_ready  input  1  consumer accepts a beat when out_valid && out_ready
beat_cnt  output  $clog2(MAX_HOLD+1)  beats transferred in the current grant

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE, gnt=0, sel=0, beat_cnt=0, rr pointer ptr=0, out_valid=0.
- out_data equals data_in[sel] at all times, including during reset.
- Arbitration function: scan indices ptr, ptr+1, ... modulo N_REQ. The first i with req[i]=1 wins.
- IDLE state:
  - If any req is high at a clock edge, then on that edge: state=GRANT, gnt=onehot(winner), sel=winner, ptr=(winner+1) mod N_REQ, beat_cnt=0.
  - Latency from req rising to gnt is 1 cycle.
- GRANT state:
  - A transfer occurs on each edge where out_valid && out_ready. Each transfer increments beat_cnt.
- Release conditions, evaluated at a clock edge while in GRANT:
  - (a) req[sel]==0, or
  - (b) a transfer occurs with beat_cnt==MAX_HOLD-1.
- On release:
  - Rearbitrate in the same edge using the already-advanced ptr.
  - If a winner exists, grant it directly. There is no idle bubble, and gnt switches one-hot to one-hot.
  - If no winner exists, go to IDLE with gnt=0. sel holds its last value.
- Forced rotation under condition (b):
  - The current owner is excluded from this rearbitration only if another req is high.
  - If the owner is the sole requester, it is re-granted with beat_cnt=0.
- Owner stall: if req[sel] stays high and out_ready stays low, the grant is held indefinitely. Stalled cycles do not count toward MAX_HOLD.
- Requests arriving mid-grant are ignored until release.
- A requester may drop req only between beats. out_valid follows req[sel] combinationally, so a dropped req never produces a transfer.
- Reset asserted mid-grant: immediate return to reset values. No beat completes on that edge.
- N_REQ=1: the single requester is always the winner; ptr stays 0.

Optional Feature:
PRIORITY_OVERRIDE_EN
- Defined:
  - Requester 0 (player sprite) wins any arbitration in which req[0]=1, regardless of ptr.
  - ptr is not advanced when requester 0 wins through override.
  - Override applies only at arbitration points. A current owner is never pre-empted mid-grant.
- Undefined: pure round-robin as described above. Requester 0 gets no special treatment.

Test Plan:
- Reset and idle: rst_n low then high with req=0 for 10 cycles -> gnt=0, sel=0, out_valid=0, beat_cnt=0 throughout.
- Single request, N_REQ=4: req=4'b0100, out_ready=1, data_in[2]=8'hA5 -> gnt=4'b0100 one cycle later, sel=2, out_data=8'hA5, out_valid=1, beat_cnt counts 0,1,2...
- Round-robin fairness: req=4'b1111 held, out_ready=1, MAX_HOLD=2 -> owners 0,1,2,3,0 in turn, each for exactly 2 beats, gnt switching with no idle cycle.
- Stall: owner 1 granted, out_ready=0 for 20 cycles with req[1]=1 -> gnt stays 4'b0010, beat_cnt frozen. Raising out_ready resumes counting.
- Release to idle and async reset: owner 3 drops req with all other reqs 0 -> next edge gnt=0, state IDLE, sel=3. Separately, pulsing rst_n low mid-grant at beat 5 -> gnt=0 and beat_cnt=0 immediately, before the next edge.
- With PRIORITY_OVERRIDE_EN: ptr=2, req=4'b1101 at arbitration -> gnt=4'b0001 and ptr stays 2. The next arbitration with req=4'b1100 grants requester 2.
